// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// restoring divide/modulo behind a start/ready/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultado,
    output logic [3:0]       flagsResult
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_flags;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_v;
    logic             w_c;
    logic [3:0]       w_flags;
    logic             w_long;

    assign ready       = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign resultado   = r_res;
    assign flagsResult = r_flags;

    assign w_long = (ALUControl == OP_MUL) || (ALUControl == OP_DIV) || (ALUControl == OP_MOD);

    // One iteration: {r_hi,r_lo} is the product for mul, {remainder,quotient} for div/mod
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + ({1'b0, r_a} & {(WIDTH + 1){r_lo[0]}});
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_b};
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_op == OP_MUL) begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_step_hi = w_trial[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_step_hi = w_rem_sh[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Final result and flags from the latched operands / iteration registers
    always_comb begin
        w_add = {1'b0, r_a} + {1'b0, r_b};
        w_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = {WIDTH{1'b0}};
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_MUL: begin
                w_res = r_lo;
                w_v   = |r_hi;
            end
            // A zero divisor naturally yields all-ones quotient and remainder = a
            OP_DIV: begin
                w_res = r_lo;
                w_v   = (r_b == {WIDTH{1'b0}});
            end
            OP_MOD: begin
                w_res = r_hi;
                w_v   = (r_b == {WIDTH{1'b0}});
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            default: w_res = {WIDTH{1'b0}};
        endcase
        w_flags = {w_res[WIDTH-1], (w_res == {WIDTH{1'b0}}), w_c, w_v};
    end

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_op    <= 3'b000;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= {WIDTH{1'b0}};
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= ALUControl;
                        r_hi    <= {WIDTH{1'b0}};
                        r_lo    <= (ALUControl == OP_MUL) ? b : a;
                        r_ready <= 1'b0;
                        if (w_long) begin
                            r_state <= S_CALC;
                            r_cnt   <= CNT_INIT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor checks on done.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  resultado;
    logic [3:0]    flagsResult;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
        int          lat;
        int          bsy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] hold_res = 32'd0;
    logic [3:0]  hold_flg = 4'd0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ALUControl(op),
        .ready(ready), .busy(busy), .done(done),
        .resultado(resultado), .flagsResult(flagsResult)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain wide arithmetic over the operation definitions
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint unsigned ux, uy, p;
        longint      sx, sy, s;
        longint      smax, smin;
        logic [31:0] r;
        logic        v, c;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = $signed(x);
        sy = $signed(y);
        smax = 64'sd2147483647;
        smin = -smax - 64'sd1;
        r = 32'd0; v = 1'b0; c = 1'b0;
        case (o)
            3'd0: begin p = ux + uy; r = p[31:0]; c = p[32]; s = sx + sy; v = (s > smax) || (s < smin); end
            3'd1: begin r = x - y; c = (x >= y); s = sx - sy; v = (s > smax) || (s < smin); end
            3'd2: begin p = ux * uy; r = p[31:0]; v = (p[63:32] != 32'd0); end
            3'd3: begin if (y == 32'd0) begin r = 32'hFFFF_FFFF; v = 1'b1; end else r = x / y; end
            3'd4: begin if (y == 32'd0) begin r = x; v = 1'b1; end else r = x % y; end
            3'd5: r = x & y;
            3'd6: r = x | y;
            default: r = x ^ y;
        endcase
        e.res = r;
        e.flg = {r[31], (r == 32'd0), c, v};
        e.acc = 0;
        e.lat = (o == 3'd2 || o == 3'd3 || o == 3'd4) ? W + 1 : 1;
        e.bsy = (o == 3'd2 || o == 3'd3 || o == 3'd4) ? W : 0;
        return e;
    endfunction

    // Monitor: checks reset state, held outputs, and each done against the scoreboard
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            hold_res = 32'd0;
            hold_flg = 4'd0;
            busy_cnt = 0;
            chk("rst_res", resultado, 32'd0);
            chk("rst_flags", flagsResult, 4'd0);
            chk("rst_ready", ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("result", resultado, e.res);
                    chk("flags", flagsResult, e.flg);
                    chk("latency", cyc - (e.acc + 1), e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
                    chk("ready_at_done", ready, 1'b1);
                    hold_res = e.res;
                    hold_flg = e.flg;
                end
                busy_cnt = 0;
            end else begin
                chk("hold_res", resultado, hold_res);
                chk("hold_flags", flagsResult, hold_flg);
                chk("ready", ready, (q.size() == 0));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
        end else begin
            op = o; a = x; b = y; start = 1'b1;
            e = model(o, x, y);
            e.acc = cyc;
            q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            a = $urandom; b = $urandom; op = 3'($urandom);
        end
    endtask

    // Hold start high through a divide; only the first request and the one in the done cycle count
    task automatic spam_div();
        exp_t e;
        logic got = 1'b0;
        while (!ready) @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        e = model(op, a, b);
        e.acc = cyc;
        q.push_back(e);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready) begin
                e = model(op, a, b);
                e.acc = cyc;
                q.push_back(e);
                @(negedge clk);
                got = 1'b1;
                break;
            end else begin
                a = $urandom; b = $urandom; op = 3'($urandom);
            end
        end
        start = 1'b0;
        chk("spam_ready_seen", got, 1'b1);
    endtask

    initial begin
        int n;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; op = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'd10, 32'd20);
        issue(3'd1, 32'd10, 32'd30);
        issue(3'd0, 32'h7FFF_FFFF, 32'd1);
        issue(3'd0, 32'hFFFF_FFFF, 32'd1);
        issue(3'd2, 32'd5, 32'd0);
        issue(3'd2, 32'h0001_0000, 32'h0001_0000);
        issue(3'd3, 32'd25, 32'd5);
        issue(3'd4, 32'd30, 32'd7);
        issue(3'd3, 32'd7, 32'd0);
        issue(3'd4, 32'd7, 32'd0);
        issue(3'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
        issue(3'd6, 32'h0000_0000, 32'h0000_0000);
        issue(3'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        issue(3'd1, 32'h8000_0000, 32'd1);

        spam_div();

        // Reset in the middle of a multiply; the pending result is discarded
        issue(3'd2, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 32'd3, 32'd4);

        // Reset and start together: the request must be dropped
        while (!ready) @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 7) == 0) x = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) y = {16'd0, y[15:0]};
            issue(3'($urandom_range(0, 7)), x, y);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, width-parametrised ALU for the Proyecto_2 CPU datapath. It supersedes the purely combinational ALU and adds an iterative multiplier, divider and modulo unit behind a start/done handshake. It also adds bitwise logic ops. The result and flags are held stable until the next operation completes. The CPU stalls on `busy` while a long op is in flight.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  WIDTH  operand A; captured on accept.
- `b`  in  WIDTH  operand B; captured on accept.
- `ALUControl`  in  3  operation select; captured on accept.
  - 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in CALC.
- `done`  out  1  one-cycle pulse when `resultado` and `flagsResult` update.
- `resultado`  out  WIDTH  result register.
- `flagsResult`  out  4  flag register:
  - [0] overflow (V)
  - [1] carry (C)
  - [2] zero (Z)
  - [3] sign (N)

## Operation
- **FSM states:** IDLE, CALC, DONE.
  - IDLE + `start`: latch `a`, `b`, `ALUControl`.
    - add/sub/logic: go to DONE.
    - mul/div/mod: go to CALC and load the iteration counter with WIDTH.
  - CALC: one iteration per cycle. Counter decrements. When the counter reaches 1, go to DONE on the next edge.
  - DONE: register result and flags, pulse `done`, return to IDLE.
- **add:** `resultado` = (a+b) mod 2^WIDTH.
  - C = carry-out.
  - V = signed overflow (operand signs equal and result sign differs).
- **sub:** computed as a + ~b + 1.
  - C = 1 iff a ≥ b unsigned (no borrow).
  - V = signed overflow.
- **mul:** unsigned shift-add, WIDTH iterations.
  - `resultado` = low WIDTH bits of the product.
  - V = 1 iff the high WIDTH bits are nonzero.
  - C = 0.
- **div / mod:** unsigned restoring division, WIDTH iterations.
  - div returns the quotient; mod returns the remainder.
  - V = 0, C = 0.
- **Divide by zero (b = 0):** still takes the full WIDTH cycles.
  - div returns all ones; mod returns `a`.
  - V = 1.
- **and / or / xor:** bitwise result; V = 0, C = 0.
- **All ops:** Z = (`resultado` == 0); N = `resultado`[WIDTH-1].
- Operand inputs may change freely after accept; only the latched copies are used.

## Timing
- **Reset values:**
  - `ready`=1, `busy`=0, `done`=0.
  - `resultado`=0, `flagsResult`=4'b0000.
  - FSM in IDLE, counter 0.
- **Accept:** rising edge with `ready`=1 and `start`=1.
- **Latency, accept edge to `done`=1:**
  - add/sub/logic: 1 cycle.
  - mul/div/mod: WIDTH+1 cycles (33 for WIDTH=32).
- `done` is high for exactly one cycle. `resultado` and `flagsResult` change only on the edge that raises `done`, and hold afterwards until the next `done`.
- `ready` is low from the accept edge until the edge that returns the FSM to IDLE. `busy` is high only in CALC.
- `start` while `ready`=0 is ignored and not queued.
- Throughput: a new `start` is accepted in the cycle after `done` (back-to-back add issues every 2 cycles).
- `rst` has priority over everything, including mid-CALC and the DONE cycle.
  - It aborts the operation without a `done` pulse.
  - All outputs take their reset values on that edge.
- `rst` and `start` asserted together: reset wins, and the request is dropped.

## Test plan
- **Add and sub (WIDTH=32):**
  - a=10, b=20, op 000 → `done` 1 cycle after accept; `resultado`=30, flags 0000.
  - a=10, b=30, op 001 → `resultado`=0xFFFFFFEC, N=1, C=0, V=0, Z=0.
- **Overflow and carry:**
  - 0x7FFFFFFF+1 → `resultado`=0x80000000, V=1, N=1, C=0.
  - 0xFFFFFFFF+1 → `resultado`=0, C=1, Z=1, V=0.
- **Multiply:**
  - 5*0 → `done` at accept+33, `resultado`=0, Z=1.
  - 0x10000*0x10000 → `resultado`=0, V=1, Z=1.
  - `busy`=1 for exactly 32 cycles in each case.
- **Divide and modulo:**
  - 25/5 → 5 at accept+33.
  - 30 mod 7 → 2.
  - 7/0 → 0xFFFFFFFF with V=1.
  - 7 mod 0 → 7 with V=1.
- **Handshake:**
  - `start` pulsed every cycle during a div → only the first request is accepted; one `done`; the next accept happens on the cycle after `done`.
  - Outputs stay stable between `done` pulses.
- **Reset mid-operation:** `rst` at cycle 10 of a mul → no `done`; outputs zero and `ready`=1 on the next cycle. A following add 3+4 returns 7 normally.
